sbn_loader: RTL

Boot loader that sits directly upstream of the SBN machine. It receives a byte stream over a valid/ready handshake, assembles instruction words and data words from it, and writes them into the machine's instruction and data memories. On a run command it raises `run`, which releases the machine from its hold. It replaces file-based memory initialisation in synthesisable builds.

---
 rtl/sbn_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sbn_loader.sv
// Byte-stream boot loader for the SBN machine: assembles instruction/data words
// from a valid/ready byte stream, writes them to imem/dmem, then releases the machine.
module sbn_loader #(
  parameter int fwidth = 8,
  parameter int dwidth = 32,
  parameter int iwidth = 4 * fwidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [fwidth-1:0] imem_addr,
  output logic [iwidth-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [fwidth-1:0] dmem_addr,
  output logic [dwidth-1:0] dmem_wdata,
  output logic              run,
  output logic              err
);

  // state   | meaning
  // S_CMD   | waiting for a command byte (NOP, imem, dmem, run)
  // S_ADDR  | next byte is the start address of the section
  // S_COUNT | next byte is word count minus one
  // S_DATA  | shifting word bytes MSB first, writing each completed word
  // S_RUN   | machine released; terminal until reset
  // S_ERR   | illegal command seen; terminal until reset

  localparam int IBYTES = (iwidth + 7) / 8;
  localparam int DBYTES = (dwidth + 7) / 8;
  localparam int AW0    = (iwidth > dwidth) ? iwidth : dwidth;
  localparam int AW     = (AW0 < 16) ? 16 : AW0;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_RUN,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                sel_dmem_q, sel_dmem_d;
  logic [fwidth-1:0]   ptr_q, ptr_d;
  logic [7:0]          words_q, words_d;
  logic [7:0]          bytes_q, bytes_d;
  logic [AW-1:0]       asm_q, asm_d;
  logic                imem_we_q, imem_we_d;
  logic [fwidth-1:0]   imem_addr_q, imem_addr_d;
  logic [iwidth-1:0]   imem_wdata_q, imem_wdata_d;
  logic                dmem_we_q, dmem_we_d;
  logic [fwidth-1:0]   dmem_addr_q, dmem_addr_d;
  logic [dwidth-1:0]   dmem_wdata_q, dmem_wdata_d;

  logic                loading;
  logic                acc;
  logic [7:0]          bytes_init;

  assign loading    = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_COUNT) || (state_q == S_DATA);
  // Gated by rst so the handshake reads as not-ready while reset is held.
  assign in_ready   = loading && !rst;
  assign acc        = in_valid && loading;
  assign bytes_init = sel_dmem_q ? 8'(DBYTES - 1) : 8'(IBYTES - 1);

  always_comb begin
    state_d      = state_q;
    sel_dmem_d   = sel_dmem_q;
    ptr_d        = ptr_q;
    words_d      = words_q;
    bytes_d      = bytes_q;
    asm_d        = asm_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    if (acc) begin
      case (state_q)
        S_CMD: begin
          case (in_data)
            8'h00: state_d = S_CMD;
            8'h01: begin
              sel_dmem_d = 1'b0;
              state_d    = S_ADDR;
            end
            8'h02: begin
              sel_dmem_d = 1'b1;
              state_d    = S_ADDR;
            end
            8'h03:   state_d = S_RUN;
            default: state_d = S_ERR;
          endcase
        end
        S_ADDR: begin
          ptr_d   = in_data[fwidth-1:0];
          state_d = S_COUNT;
        end
        S_COUNT: begin
          words_d = in_data;
          bytes_d = bytes_init;
          state_d = S_DATA;
        end
        S_DATA: begin
          // Bits shifted past the word width fall off when the word is sliced out.
          asm_d = (asm_q << 8) | AW'(in_data);
          if (bytes_q == 8'd0) begin
            bytes_d = bytes_init;
            ptr_d   = ptr_q + fwidth'(1);
            if (sel_dmem_q) begin
              dmem_we_d    = 1'b1;
              dmem_addr_d  = ptr_q;
              dmem_wdata_d = asm_d[dwidth-1:0];
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = ptr_q;
              imem_wdata_d = asm_d[iwidth-1:0];
            end
            if (words_q == 8'd0) state_d = S_CMD;
            else                 words_d = words_q - 8'd1;
          end else begin
            bytes_d = bytes_q - 8'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CMD;
      sel_dmem_q   <= 1'b0;
      ptr_q        <= '0;
      words_q      <= '0;
      bytes_q      <= '0;
      asm_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_dmem_q   <= sel_dmem_d;
      ptr_q        <= ptr_d;
      words_q      <= words_d;
      bytes_q      <= bytes_d;
      asm_q        <= asm_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign run        = (state_q == S_RUN);
  assign err        = (state_q == S_ERR);

endmodule
